acc_seq: RTL and testbench

ACC_SEQ -- requirements
Module: acc_seq

---
 rtl/acc_seq_pkg.sv | 17 +
 rtl/acc_seq_bias_rf.sv | 28 ++
 rtl/acc_seq.sv | 149 ++++++++++++++
 tb/tb_acc_seq.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_seq_pkg.sv
// Shared accelerator definitions: default widths/depths
// and the sequencer state encoding.
package acc_seq_pkg;

  localparam int BIT_WIDTH_DEF  = 12;
  localparam int BIAS_WIDTH_DEF = 12;
  localparam int CHN_MAX_DEF    = 32;
  localparam int OCH_MAX_DEF    = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_CAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/acc_seq_bias_rf.sv
// Per-output-channel bias table: one synchronous write
// port, one combinational read port, no reset.
module bias_rf
  import acc_seq_pkg::*;
#(
  parameter int DEPTH = OCH_MAX_DEF,
  parameter int WIDTH = BIAS_WIDTH_DEF,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [AW-1:0]           waddr,
  input  logic signed [WIDTH-1:0] wdata,
  input  logic [AW-1:0]           raddr,
  output logic signed [WIDTH-1:0] rdata
);

  logic signed [WIDTH-1:0] mem [DEPTH];

  // Write port; contents survive reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read sees the pre-write value in a same-cycle collision
  assign rdata = mem[raddr];

endmodule

// File: rtl/acc_seq.sv
// Accumulator sequencer: counts input beats per output
// channel, steers bias/new_bias, captures saturated results.
module acc_seq
  import acc_seq_pkg::*;
#(
  parameter int BIT_WIDTH  = BIT_WIDTH_DEF,
  parameter int BIAS_WIDTH = BIAS_WIDTH_DEF,
  parameter int CHN_MAX    = CHN_MAX_DEF,
  parameter int OCH_MAX    = OCH_MAX_DEF,
  localparam int CW = $clog2(CHN_MAX + 1),
  localparam int OW = $clog2(OCH_MAX + 1),
  localparam int AW = $clog2(OCH_MAX)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cfg_start,
  input  logic [CW-1:0]                cfg_num_chn,
  input  logic [OW-1:0]                cfg_num_och,
  output logic                         busy,
  output logic                         done,
  input  logic                         bias_we,
  input  logic [AW-1:0]                bias_addr,
  input  logic signed [BIAS_WIDTH-1:0] bias_wdata,
  input  logic                         x_valid,
  output logic                         x_ready,
  output logic                         acc_in_enable,
  output logic                         acc_new_bias,
  output logic signed [BIAS_WIDTH-1:0] acc_bias,
  input  logic signed [BIT_WIDTH-1:0]  acc_y,
  output logic                         y_valid,
  input  logic                         y_ready,
  output logic signed [BIT_WIDTH-1:0]  y_data,
  output logic [AW-1:0]                y_och
);

  state_t        state;
  logic [CW-1:0] chn_cnt;
  logic [CW-1:0] num_chn;
  logic [AW-1:0] och_cnt;
  logic [OW-1:0] num_och;

  logic last_chn;
  logic last_och;
  logic cap_load;
  logic drain;
  logic cfg_zero;

  assign x_ready       = (state == S_RUN);
  assign acc_in_enable = x_valid & x_ready;
  assign acc_new_bias  = acc_in_enable
                       & (chn_cnt == '0);

  assign last_chn = (chn_cnt == num_chn - CW'(1));
  assign last_och = (OW'(och_cnt)
                  == num_och - OW'(1));
  assign drain    = y_valid & y_ready;
  assign cap_load = (state == S_CAP)
                  & (~y_valid | y_ready);
  assign cfg_zero = (cfg_num_chn == '0)
                  | (cfg_num_och == '0);

  bias_rf #(
    .DEPTH (OCH_MAX),
    .WIDTH (BIAS_WIDTH)
  ) u_bias_rf (
    .clk   (clk),
    .we    (bias_we),
    .waddr (bias_addr),
    .wdata (bias_wdata),
    .raddr (och_cnt),
    .rdata (acc_bias)
  );

  // Job sequencing FSM with registered busy/done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      chn_cnt <= '0;
      och_cnt <= '0;
      num_chn <= '0;
      num_och <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (cfg_start) begin
            num_chn <= cfg_num_chn;
            num_och <= cfg_num_och;
            chn_cnt <= '0;
            och_cnt <= '0;
            if (cfg_zero) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_RUN;
              busy  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (acc_in_enable) begin
            if (last_chn) begin
              chn_cnt <= '0;
              state   <= S_CAP;
            end else begin
              chn_cnt <= chn_cnt + CW'(1);
            end
          end
        end
        S_CAP: begin
          if (cap_load) begin
            if (last_och) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              och_cnt <= och_cnt + AW'(1);
              state   <= S_RUN;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Result register: load on capture, clear on drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_valid <= 1'b0;
      y_data  <= '0;
      y_och   <= '0;
    end else if (cap_load) begin
      y_valid <= 1'b1;
      y_data  <= acc_y;
      y_och   <= och_cnt;
    end else if (drain) begin
      y_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_acc_seq.sv
// Bench for acc_seq: behavioural accumulator beside the
// DUT, scoreboard of expected (data, och) results.
module tb_acc_seq;

  localparam int BW  = 12;
  localparam int BIW = 12;
  localparam int CHN = 32;
  localparam int OCH = 16;
  localparam int CW  = $clog2(CHN + 1);
  localparam int OW  = $clog2(OCH + 1);
  localparam int AW  = $clog2(OCH);
  localparam int YMAX = (1 << (BW - 1)) - 1;

  typedef struct {
    int d;
    int o;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  cfg_start = 1'b0;
  logic [CW-1:0]         cfg_num_chn = '0;
  logic [OW-1:0]         cfg_num_och = '0;
  logic                  busy;
  logic                  done;
  logic                  bias_we = 1'b0;
  logic [AW-1:0]         bias_addr = '0;
  logic signed [BIW-1:0] bias_wdata = '0;
  logic                  x_valid = 1'b0;
  logic                  x_ready;
  logic                  acc_in_enable;
  logic                  acc_new_bias;
  logic signed [BIW-1:0] acc_bias;
  logic signed [BW-1:0]  acc_y;
  logic                  y_valid;
  logic                  y_ready = 1'b1;
  logic signed [BW-1:0]  y_data;
  logic [AW-1:0]         y_och;

  logic signed [BW-1:0]  x_data = '0;
  logic                  bubbles = 1'b0;
  logic                  nb_chk = 1'b0;
  int                    acc_r;

  exp_t sbq[$];
  int   shadow [OCH];
  int   n_chk = 0;
  int   n_pass = 0;
  int   done_cnt = 0;
  int   busy_cnt = 0;
  int   yv_cnt = 0;

  acc_seq dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_start     (cfg_start),
    .cfg_num_chn   (cfg_num_chn),
    .cfg_num_och   (cfg_num_och),
    .busy          (busy),
    .done          (done),
    .bias_we       (bias_we),
    .bias_addr     (bias_addr),
    .bias_wdata    (bias_wdata),
    .x_valid       (x_valid),
    .x_ready       (x_ready),
    .acc_in_enable (acc_in_enable),
    .acc_new_bias  (acc_new_bias),
    .acc_bias      (acc_bias),
    .acc_y         (acc_y),
    .y_valid       (y_valid),
    .y_ready       (y_ready),
    .y_data        (y_data),
    .y_och         (y_och)
  );

  always #5 clk = ~clk;

  // Behavioural accumulator: bias+x on new_bias, else acc+x
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_r <= 0;
    else if (acc_in_enable)
      acc_r <= (acc_new_bias ? int'(acc_bias) : acc_r)
             + int'(x_data);
  end

  assign acc_y = (acc_r < 0) ? '0 :
                 (acc_r > YMAX) ? BW'(YMAX) :
                 acc_r[BW-1:0];

  // Upstream valid, optionally with random bubbles
  always @(posedge clk) begin
    #1;
    x_valid = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic check(input string tag,
                       input int got,
                       input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d",
                  tag, got, exp);
  endtask

  function automatic int clampf(input int s);
    if (s < 0) return 0;
    if (s > YMAX) return YMAX;
    return s;
  endfunction

  // Output monitor and scoreboard pop
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (done) done_cnt++;
      if (busy) busy_cnt++;
      if (y_valid) yv_cnt++;
      if (nb_chk && acc_in_enable)
        check("new_bias_n1", int'(acc_new_bias), 1);
      if (y_valid && y_ready) begin
        check("sb_nonempty", int'(sbq.size() != 0), 1);
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          check("y_data", int'(y_data), e.d);
          check("y_och", int'(y_och), e.o);
        end
      end
    end
  end

  task automatic write_bias(input int a, input int v);
    @(posedge clk);
    #1;
    bias_we    = 1'b1;
    bias_addr  = AW'(a);
    bias_wdata = BIW'(v);
    @(posedge clk);
    #1;
    bias_we = 1'b0;
    shadow[a] = v;
  endtask

  task automatic start_job(input int nc, input int no,
                           input int xv);
    exp_t e;
    if (nc > 0) begin
      for (int o = 0; o < no; o++) begin
        e.d = clampf(shadow[o] + nc * xv);
        e.o = o;
        sbq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    x_data      = BW'(xv);
    cfg_num_chn = CW'(nc);
    cfg_num_och = OW'(no);
    cfg_start   = 1'b1;
    @(posedge clk);
    #1;
    cfg_start = 1'b0;
  endtask

  task automatic wait_done(input string tag,
                           input int bound);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check({tag, "_done1"}, done_cnt - d0, 1);
    check({tag, "_sb_empty"}, sbq.size(), 0);
  endtask

  task automatic wait_yv(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!y_valid && lat < 100);
  endtask

  initial begin
    int lat;
    int d0;
    int b0;
    int v0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_x_ready", int'(x_ready), 0);
    check("rst_y_valid", int'(y_valid), 0);
    check("rst_in_en", int'(acc_in_enable), 0);
    check("rst_new_bias", int'(acc_new_bias), 0);
    check("rst_y_data", int'(y_data), 0);
    check("rst_y_och", int'(y_och), 0);
    rst_n = 1'b1;

    write_bias(0, 5);
    write_bias(1, -3);
    @(negedge clk);
    check("idle_bias0", int'(acc_bias), 5);

    start_job(3, 2, 10);
    wait_yv(lat);
    check("latency", lat, 5);
    wait_done("basic", 200);

    y_ready = 1'b0;
    start_job(3, 2, 10);
    wait_yv(lat);
    check("stall_latency", lat, 5);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("stall_x_ready", int'(x_ready), 0);
    check("stall_in_en", int'(acc_in_enable), 0);
    check("stall_busy", int'(busy), 1);
    check("stall_y_valid", int'(y_valid), 1);
    check("stall_y_data", int'(y_data), 35);
    check("stall_y_och", int'(y_och), 0);
    @(posedge clk);
    #1;
    y_ready = 1'b1;
    wait_done("stall", 200);

    for (int z = 0; z < 2; z++) begin
      d0 = done_cnt;
      b0 = busy_cnt;
      v0 = yv_cnt;
      start_job(z == 0 ? 0 : 3, z == 0 ? 2 : 0, 10);
      @(negedge clk);
      check("zero_done", int'(done), 1);
      check("zero_busy", int'(busy), 0);
      repeat (3) @(negedge clk);
      check("zero_done_cnt", done_cnt - d0, 1);
      check("zero_busy_cnt", busy_cnt - b0, 0);
      check("zero_yv_cnt", yv_cnt - v0, 0);
    end

    write_bias(0, 2047);
    start_job(2, 1, 100);
    wait_done("sat", 200);

    write_bias(0, -50);
    write_bias(2, 7);
    nb_chk = 1'b1;
    start_job(1, 3, 10);
    wait_done("relu_n1", 200);
    nb_chk = 1'b0;

    write_bias(0, 5);
    bubbles = 1'b1;
    start_job(5, 3, 9);
    wait_done("bubbles", 600);
    bubbles = 1'b0;

    start_job(4, 2, 10);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_x_ready", int'(x_ready), 0);
    check("mid_rst_in_en", int'(acc_in_enable), 0);
    check("mid_rst_new_bias", int'(acc_new_bias), 0);
    check("mid_rst_y_valid", int'(y_valid), 0);
    check("mid_rst_done", int'(done), 0);
    sbq.delete();
    d0 = done_cnt;
    v0 = yv_cnt;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("mid_rst_no_done", done_cnt - d0, 0);
    check("mid_rst_no_y", yv_cnt - v0, 0);
    start_job(4, 2, 10);
    wait_done("after_rst", 200);

    start_job(3, 2, 10);
    @(posedge clk);
    #1;
    cfg_start   = 1'b1;
    cfg_num_chn = CW'(1);
    cfg_num_och = OW'(1);
    bias_we     = 1'b1;
    bias_addr   = AW'(0);
    bias_wdata  = BIW'(100);
    @(negedge clk);
    check("wr_same_cycle_old", int'(acc_bias), 5);
    @(posedge clk);
    #1;
    cfg_start = 1'b0;
    bias_we   = 1'b0;
    shadow[0] = 100;
    @(negedge clk);
    check("wr_next_cycle_new", int'(acc_bias), 100);
    check("restart_busy", int'(busy), 1);
    wait_done("restart", 200);
    start_job(3, 1, 10);
    wait_done("new_bias_job", 200);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
